// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: shared timing defaults, colours and coordinate types for the RGB-LCD path
package lcd_timing_pkg;

    localparam int COORD_W   = 11;
    localparam int MAX_TOTAL = 2048;

    localparam int H_SYNC_D  = 1;
    localparam int H_BACK_D  = 46;
    localparam int H_VALID_D = 800;
    localparam int H_FRONT_D = 210;
    localparam int V_SYNC_D  = 1;
    localparam int V_BACK_D  = 23;
    localparam int V_VALID_D = 480;
    localparam int V_FRONT_D = 22;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   wide_t;
    typedef logic [23:0]        rgb_t;

    localparam rgb_t BLACK  = 24'h000000;
    localparam rgb_t WHITE  = 24'hFFFFFF;
    localparam rgb_t GRAY   = 24'h808080;
    localparam rgb_t ORANGE = 24'hFF8000;
    localparam rgb_t YELLOW = 24'hFFFF00;
    localparam rgb_t RED    = 24'hFF0000;

    // An axis is usable only with a visible region and a period the 11-bit counter can hold.
    function automatic bit timing_ok(int s, int b, int v, int f);
        return v > 0 && s + b + v + f <= MAX_TOTAL;
    endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// lcd_axis_cnt: one timing axis (sync, back porch, active, front porch) with window decode
module lcd_axis_cnt
    import lcd_timing_pkg::*;
#(
    parameter int SYNC  = H_SYNC_D,
    parameter int BACK  = H_BACK_D,
    parameter int VALID = H_VALID_D,
    parameter int FRONT = H_FRONT_D
) (
    input  logic   clk_in,
    input  logic   sys_rst_n,
    input  logic   inc,
    output coord_t cnt,
    output logic   wrap,
    output logic   in_sync,
    output logic   in_act,
    output coord_t coord
);

    localparam int     TOTAL   = SYNC + BACK + VALID + FRONT;
    localparam coord_t LAST    = coord_t'(TOTAL - 1);
    localparam coord_t START_C = coord_t'(SYNC + BACK);
    localparam wide_t  START_W = wide_t'(SYNC + BACK);
    localparam wide_t  END_W   = wide_t'(SYNC + BACK + VALID);
    localparam wide_t  SYNC_W  = wide_t'(SYNC);

    if (!timing_ok(SYNC, BACK, VALID, FRONT)) begin : g_bad_timing
        $error("lcd_axis_cnt: VALID must be nonzero and the axis total must not exceed 2048");
    end

    coord_t cnt_q, cnt_d;
    wide_t  cnt_w;

    assign cnt_w = {1'b0, cnt_q};

    // Next count and window decode; the wider compare keeps an end of 2048 representable.
    always_comb begin
        wrap    = inc && cnt_q == LAST;
        cnt_d   = wrap ? '0 : inc ? cnt_q + coord_t'(1) : cnt_q;
        in_sync = cnt_w < SYNC_W;
        in_act  = cnt_w >= START_W && cnt_w < END_W;
        coord   = in_act ? cnt_q - START_C : '0;
    end

    // Counter register, cleared straight back to the axis origin.
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/lcd_timing_driver.sv
// lcd_timing_driver: RGB-LCD timing generator issuing pixel requests and registering panel signals
module lcd_timing_driver
    import lcd_timing_pkg::*;
#(
    parameter int   H_SYNC   = H_SYNC_D,
    parameter int   H_BACK   = H_BACK_D,
    parameter int   H_VALID  = H_VALID_D,
    parameter int   H_FRONT  = H_FRONT_D,
    parameter int   V_SYNC   = V_SYNC_D,
    parameter int   V_BACK   = V_BACK_D,
    parameter int   V_VALID  = V_VALID_D,
    parameter int   V_FRONT  = V_FRONT_D,
    parameter logic SYNC_ACT = 1'b0
) (
    input  logic         clk_in,
    input  logic         sys_rst_n,
    input  logic [23:0]  pix_data,
    output logic [10:0]  pix_x,
    output logic [10:0]  pix_y,
    output logic         pix_req,
    output logic         lcd_hsync,
    output logic         lcd_vsync,
    output logic         lcd_de,
    output logic [23:0]  lcd_rgb,
    output logic         frame_start
);

    coord_t h_cnt, v_cnt, h_coord, v_coord;
    logic   h_wrap, h_sync, h_act, v_sync, v_act, unused_v_wrap;
    logic   hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
    rgb_t   rgb_q, rgb_d;

    lcd_axis_cnt #(.SYNC(H_SYNC), .BACK(H_BACK), .VALID(H_VALID), .FRONT(H_FRONT)) u_h (
        .clk_in    (clk_in),
        .sys_rst_n (sys_rst_n),
        .inc       (1'b1),
        .cnt       (h_cnt),
        .wrap      (h_wrap),
        .in_sync   (h_sync),
        .in_act    (h_act),
        .coord     (h_coord)
    );

    lcd_axis_cnt #(.SYNC(V_SYNC), .BACK(V_BACK), .VALID(V_VALID), .FRONT(V_FRONT)) u_v (
        .clk_in    (clk_in),
        .sys_rst_n (sys_rst_n),
        .inc       (h_wrap),
        .cnt       (v_cnt),
        .wrap      (unused_v_wrap),
        .in_sync   (v_sync),
        .in_act    (v_act),
        .coord     (v_coord)
    );

    assign pix_req = h_act & v_act;
    assign pix_x   = pix_req ? h_coord : '0;
    assign pix_y   = pix_req ? v_coord : '0;

    // Panel outputs for the coordinate presented this cycle; pixel data outside the window is dropped.
    always_comb begin
        de_d    = pix_req;
        rgb_d   = pix_req ? pix_data : BLACK;
        hsync_d = h_sync ? SYNC_ACT : ~SYNC_ACT;
        vsync_d = v_sync ? SYNC_ACT : ~SYNC_ACT;
        fs_d    = h_cnt == '0 && v_cnt == '0;
    end

    // One-cycle output stage keeping data, enable and syncs aligned at the pins.
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            de_q    <= 1'b0;
            rgb_q   <= BLACK;
            hsync_q <= ~SYNC_ACT;
            vsync_q <= ~SYNC_ACT;
            fs_q    <= 1'b0;
        end else begin
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
        end
    end

    assign lcd_de      = de_q;
    assign lcd_rgb     = rgb_q;
    assign lcd_hsync   = hsync_q;
    assign lcd_vsync   = vsync_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_timing_driver.sv
// tb_lcd_timing_driver: randomized scoreboard bench for the small-parameter 10x6 timing
module tb_lcd_timing_driver;

    localparam int HS = 2, HB = 3, HV = 4, HF = 1;
    localparam int VS = 1, VB = 1, VV = 3, VF = 1;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;

    typedef struct {
        logic        de;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] pix_data = '0;
    logic [10:0] pix_x, pix_y;
    logic        pix_req, lcd_hsync, lcd_vsync, lcd_de, frame_start;
    logic [23:0] lcd_rgb;

    exp_t q[$];
    int total = 0, bad = 0;
    int de_seen = 0, fs_seen = 0, hs_low = 0, vs_low = 0;

    lcd_timing_driver #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
        .SYNC_ACT(1'b0)
    ) dut (
        .clk_in      (clk),
        .sys_rst_n   (rst_n),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_req     (pix_req),
        .lcd_hsync   (lcd_hsync),
        .lcd_vsync   (lcd_vsync),
        .lcd_de      (lcd_de),
        .lcd_rgb     (lcd_rgb),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle t after reset release: position is plain modular arithmetic over the frame.
    task automatic step(input int t);
        int h, v, mode;
        logic req;
        exp_t e;
        h   = t % HT;
        v   = (t / HT) % VT;
        req = h >= HS + HB && h < HS + HB + HV && v >= VS + VB && v < VS + VB + VV;
        chk("pix_req", 32'(pix_req), 32'(req));
        chk("pix_x", 32'(pix_x), req ? h - (HS + HB) : 0);
        chk("pix_y", 32'(pix_y), req ? v - (VS + VB) : 0);
        mode = $urandom_range(0, 2);
        pix_data = mode == 0 ? 24'($urandom) : mode == 1 ? {pix_y[7:0], pix_x[7:0], 8'hA5} : 24'hFFFFFF;
        e.de  = req;
        e.rgb = req ? pix_data : 24'h0;
        e.hs  = h >= HS;
        e.vs  = v >= VS;
        e.fs  = h == 0 && v == 0;
        q.push_back(e);
    endtask

    // Monitor: after each edge the registered outputs answer the oldest issued cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("lcd_de", 32'(lcd_de), 32'(e.de));
            chk("lcd_rgb", 32'(lcd_rgb), 32'(e.rgb));
            chk("lcd_hsync", 32'(lcd_hsync), 32'(e.hs));
            chk("lcd_vsync", 32'(lcd_vsync), 32'(e.vs));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
            de_seen += int'(lcd_de);
            fs_seen += int'(frame_start);
            hs_low  += int'(!lcd_hsync);
            vs_low  += int'(!lcd_vsync);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_de", 32'(lcd_de), 0);
        chk("rst_rgb", 32'(lcd_rgb), 0);
        chk("rst_hsync", 32'(lcd_hsync), 1);
        chk("rst_vsync", 32'(lcd_vsync), 1);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_req", 32'(pix_req), 0);
        chk("rst_x", 32'(pix_x), 0);
        chk("rst_y", 32'(pix_y), 0);
        rst_n = 1'b1;
        for (int t = 0; t < 36; t++) begin
            step(t);
            @(negedge clk);
        end
        chk("pre_rst_req", 32'(pix_req), 1);
        chk("pre_rst_de", 32'(lcd_de), 1);
        rst_n = 1'b0;
        #1;
        chk("async_de", 32'(lcd_de), 0);
        chk("async_rgb", 32'(lcd_rgb), 0);
        chk("async_hsync", 32'(lcd_hsync), 1);
        chk("async_vsync", 32'(lcd_vsync), 1);
        chk("async_req", 32'(pix_req), 0);
        chk("async_x", 32'(pix_x), 0);
        repeat (2) @(negedge clk);
        de_seen = 0;
        fs_seen = 0;
        hs_low  = 0;
        vs_low  = 0;
        rst_n = 1'b1;
        for (int t = 0; t < 3 * HT * VT; t++) begin
            step(t);
            @(negedge clk);
        end
        chk("queue_drained", 32'(q.size()), 0);
        chk("de_per_3_frames", 32'(de_seen), 36);
        chk("fs_per_3_frames", 32'(fs_seen), 3);
        chk("hsync_low_cycles", 32'(hs_low), 36);
        chk("vsync_low_cycles", 32'(vs_low), 30);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
